regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Sequential reader for the CPU register file's single shared read/write port.
- On a start pulse it walks every register address in ascending order through the port and captures each returned value.
- Each word is emitted on a valid/ready stream with its address and a last flag.
- Used by the debug/trace path to snapshot architectural state (e.g. end-of-test dump) without touching pipeline logic.

Parameters:
- W, 32, register data width in bits
- A, 5, register address width; register count is 1<<A

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a dump; honoured only in IDLE
- busy  output  1  high from the cycle after start is accepted until the DONE state
- done  output  1  one-cycle pulse after the final word handshake
- rf_write_enable  output  1  drives the register file write_enable; constant 0
- rf_read_addr  output  A  address to the register file port
- rf_read_data  input  W  register file read output; valid the cycle after the address is sampled
- out_valid  output  1  stream word valid
- out_ready  input  1  downstream accepts the word when valid&ready at posedge
- out_data  output  W  register value
- out_addr  output  A  register index of out_data
- out_last  output  1  high with the final word of a dump

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, out_addr=0, rf_read_addr=0, rf_write_enable=0; state=IDLE, address counter=0.
- Reset has priority over everything and aborts a dump in progress. An in-flight word is dropped, and no done pulse follows.
- rf_write_enable is 0 in every state. The reader never writes the register file.
- State machine:
  - IDLE: start=1 loads counter with the first address (0) -> ISSUE. Otherwise stay.
  - ISSUE: drive rf_read_addr=counter -> CAPTURE.
  - CAPTURE: hold rf_read_addr. At the clock edge, latch rf_read_data into out_data and counter into out_addr. Set out_valid=1 and out_last=(counter==last address) -> SEND.
  - SEND: hold out_valid, out_data, out_addr and out_last stable while out_ready=0.
    - On valid&ready with out_last=0: clear out_valid, increment counter -> ISSUE.
    - On valid&ready with out_last=1: clear out_valid and out_last -> DONE.
  - DONE: done=1 for exactly this cycle; start ignored -> IDLE.
- Register 0 reads as 0 via the register file's hardwired behaviour. The reader still emits it as a normal word.
- Latency:
  - Accepting start at edge k gives ISSUE in cycle k+1 and CAPTURE in k+2; the first out_valid is seen in cycle k+3.
  - With out_ready held 1, each word costs 3 cycles, so a full dump is 3*(1<<A) cycles plus one DONE cycle.
- Counter wrap: the counter is A bits. The last address is (1<<A)-1, and the FSM leaves SEND via out_last before the counter increments, so no wrap occurs.
- A start pulse in ISSUE, CAPTURE, SEND or DONE is ignored and not queued.
- out_ready while out_valid=0 has no effect.
- rf_read_addr outside ISSUE/CAPTURE holds its last value.

Optional Feature:
- Macro: REGFILE_DUMP_SKIP_X0_EN.
- Defined:
  - The counter starts at 1 and address 0 is never emitted, so a dump is (1<<A)-1 words.
  - A full dump with out_ready=1 is 3*((1<<A)-1) cycles plus one DONE cycle.
  - out_last is still on address (1<<A)-1.
- Undefined: the dump starts at address 0 and emits 1<<A words, as described above.

Test Plan:
- Full dump, ready always high: register file preloaded with reg[i]=i*10+1 (reg0 reads 0), pulse start -> 32 words, addr 0..31, data 0,11,21,...,311, out_last only on addr 31; first out_valid 3 cycles after start; done pulses in cycle 97 after start; busy then drops.
- Backpressure: out_ready=0 for 5 cycles while SEND holds addr 4 -> out_valid, out_data=41 and out_addr=4 stay stable all 5 cycles. Releasing ready gives exactly one handshake, and the next word is addr 5, data 51.
- Start while busy: second start pulse during word 10 -> ignored; exactly 32 words and one done pulse total.
- Reset mid-dump: assert reset during SEND of addr 7 -> next cycle all outputs 0 and IDLE, no done pulse. A new start then dumps from addr 0 again.
- Write safety: sample rf_write_enable every cycle of a dump -> always 0. A re-read after the dump gives unchanged register contents.
- With REGFILE_DUMP_SKIP_X0_EN defined: same preload -> 31 words, first addr 1 data 11, last addr 31 data 311 with out_last.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if
// Bundles the register-file port and the output word stream of the
// register dump reader.
//   rf_write_enable : write enable to the register file (reader drives 0)
//   rf_read_addr    : register address presented to the shared port
//   rf_read_data    : register value, valid the cycle after the address is sampled
//   out_valid/ready : valid/ready handshake of the dump stream
//   out_data        : register value of the current word
//   out_addr        : register index of out_data
//   out_last        : marks the final word of a dump
// master: the reader side. slave: register file + stream consumer side.
interface regfile_dump_reader_if #(
  parameter int W = 32,
  parameter int A = 5
);
  logic         rf_write_enable;
  logic [A-1:0] rf_read_addr;
  logic [W-1:0] rf_read_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [A-1:0] out_addr;
  logic         out_last;

  modport master (
    output rf_write_enable,
    output rf_read_addr,
    input  rf_read_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_addr,
    output out_last
  );

  modport slave (
    input  rf_write_enable,
    input  rf_read_addr,
    output rf_read_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_addr,
    input  out_last
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks every register address in ascending order through the register
// file's shared port and emits each value on a valid/ready stream with its
// address and a last flag. Used to snapshot architectural state.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous active-high reset, aborts a dump in progress
//   start : one-cycle dump request, honoured only when idle
//   busy  : high while the dump is walking addresses (ISSUE/CAPTURE/SEND)
//   done  : one-cycle pulse after the final word handshake
//   bus   : regfile_dump_reader_if.master (register file port + stream)
// Optional feature macro: REGFILE_DUMP_SKIP_X0_EN
//   defined   -> dump starts at address 1 (x0 never emitted)
//   undefined -> dump starts at address 0
module regfile_dump_reader #(
  parameter int W = 32,
  parameter int A = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  regfile_dump_reader_if.master       bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

`ifdef REGFILE_DUMP_SKIP_X0_EN
  localparam logic [A-1:0] FIRST_ADDR = A'(1);
`else
  localparam logic [A-1:0] FIRST_ADDR = '0;
`endif
  localparam logic [A-1:0] LAST_ADDR = '1;

  state_t       state_q, state_d;
  logic [A-1:0] cnt_q, cnt_d;
  logic [A-1:0] rd_addr_q, rd_addr_d;
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [A-1:0] oaddr_q, oaddr_d;
  logic         last_q, last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      oaddr_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      oaddr_q   <= oaddr_d;
      last_q    <= last_d;
    end
  end

  // The read address register is loaded on every transition into ISSUE so
  // that it already equals the counter during the ISSUE cycle and is held
  // through CAPTURE and beyond.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    valid_d   = valid_q;
    data_d    = data_q;
    oaddr_d   = oaddr_q;
    last_d    = last_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d     = FIRST_ADDR;
          rd_addr_d = FIRST_ADDR;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_d  = bus.rf_read_data;
        oaddr_d = cnt_q;
        valid_d = 1'b1;
        last_d  = (cnt_q == LAST_ADDR);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            cnt_d     = cnt_q + A'(1);
            rd_addr_d = cnt_q + A'(1);
            state_d   = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy                = (state_q == S_ISSUE) || (state_q == S_CAPTURE) ||
                               (state_q == S_SEND);
  assign done                = (state_q == S_DONE);
  assign bus.rf_write_enable = 1'b0;
  assign bus.rf_read_addr    = rd_addr_q;
  assign bus.out_valid       = valid_q;
  assign bus.out_data        = data_q;
  assign bus.out_addr        = oaddr_q;
  assign bus.out_last        = last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;
  localparam int W = 32;
  localparam int A = 5;
  localparam int N = 1 << A;
`ifdef REGFILE_DUMP_SKIP_X0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NW = N - FIRST;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic load = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] gold [N];
  logic [W-1:0] mem  [N];

  regfile_dump_reader_if #(.W(W), .A(A)) bus ();

  regfile_dump_reader #(.W(W), .A(A)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Register file: synchronous read, x0 hardwired to zero. A write from the
  // reader would flip the addressed word so it cannot go unnoticed.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= gold[i];
    end else if (bus.rf_write_enable) begin
      mem[bus.rf_read_addr] <= ~mem[bus.rf_read_addr];
    end
    bus.rf_read_data <= (bus.rf_read_addr == '0) ? '0 : mem[bus.rf_read_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gold_rd(input int a);
    return (a == 0) ? '0 : gold[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of addresses still owed to the stream, the
  // number of edges since the last accept/handshake, and the dump-active flag.
  task automatic compare_loop();
    int  q[$];
    int  since;
    bit  active, done_due, nxt_done, hs, accept;
    int  a;
    since = 0; active = 0; done_due = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        since = 0; active = 0; done_due = 0;
        continue;
      end
      check("we", bus.rf_write_enable, 0);
      check("done", done, done_due);
      check("busy", busy, active && !done_due);
      check("valid", bus.out_valid, (q.size() > 0) && (since >= 3));
      hs = 0;
      if (bus.out_valid && q.size() > 0) begin
        a = q[0];
        check("addr", bus.out_addr, a);
        check("data", bus.out_data, gold_rd(a));
        check("last", bus.out_last, a == N - 1);
        hs = bus.out_ready;
      end
      accept = start && !active;
      if (done_due) active = 0;
      nxt_done = 0;
      if (hs) begin
        void'(q.pop_front());
        if (q.size() == 0) nxt_done = 1;
        since = 1;
      end else if (accept) begin
        active = 1;
        for (int i = FIRST; i < N; i++) q.push_back(i);
        since = 1;
      end else if (since < 1000) begin
        since++;
      end
      done_due = nxt_done;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3 * N + 10) tick();
  endtask

  task automatic wait_valid_addr(input int addr, input string name);
    int n;
    n = 0;
    while (!(bus.out_valid && bus.out_addr == A'(addr)) && n < 4 * N) begin
      tick();
      n++;
    end
    check(name, n < 4 * N, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_last"}, bus.out_last, 0);
    check({tag, "_data"}, bus.out_data, 0);
    check({tag, "_oaddr"}, bus.out_addr, 0);
    check({tag, "_raddr"}, bus.rf_read_addr, 0);
    check({tag, "_we"}, bus.rf_write_enable, 0);
  endtask

  initial begin
    int n, first_v, done_n, words, dones;
    bit pulsed;

    fork
      compare_loop();
    join_none

    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) gold[i] = i * 10 + 1;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("rst");

    // Full dump with ready held high: latency and literal end points
    bus.out_ready = 1'b1;
    tick();
    pulse_start();
    n = 1; first_v = -1; done_n = -1; words = 0;
    while (n <= 4 * N) begin
      @(negedge clk);
      if (n == 1) check("busy_first", busy, 1);
      if (bus.out_valid && first_v < 0) first_v = n;
      if (bus.out_valid && bus.out_ready) begin
        words++;
        if (int'(bus.out_addr) == FIRST)
          check("first_data", bus.out_data, (FIRST == 0) ? 0 : 11);
        if (int'(bus.out_addr) == N - 1) begin
          check("final_data", bus.out_data, 311);
          check("final_last", bus.out_last, 1);
        end
      end
      if (done) begin
        done_n = n;
        break;
      end
      tick();
      n++;
    end
    check("first_valid_cycle", first_v, 3);
    check("done_cycle", done_n, 3 * NW + 1);
    check("word_count", words, NW);
    check("busy_in_done", busy, 0);
    tick();
    @(negedge clk);
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    tick();

    // Backpressure on address 4
    bus.out_ready = 1'b1;
    pulse_start();
    wait_valid_addr(4, "found_a4");
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_addr", bus.out_addr, 4);
      check("hold_data", bus.out_data, 41);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    n = 0;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    @(negedge clk);
    check("next_addr", bus.out_addr, 5);
    check("next_data", bus.out_data, 51);
    drain();

    // Start while busy is ignored
    pulse_start();
    pulsed = 0; words = 0; dones = 0;
    for (int c = 0; c < 3 * N + 30; c++) begin
      start = (!pulsed && bus.out_valid && bus.out_addr == A'(10));
      if (start) pulsed = 1;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) words++;
      if (done) dones++;
      tick();
    end
    start = 1'b0;
    check("busy_start_words", words, NW);
    check("busy_start_dones", dones, 1);

    // Reset during SEND of address 7
    pulse_start();
    wait_valid_addr(7, "found_a7");
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    bus.out_ready = 1'b1;
    dones = 0;
    repeat (3 * N + 10) begin
      @(negedge clk);
      if (done) dones++;
      tick();
    end
    check("abort_no_done", dones, 0);
    pulse_start();
    n = 0;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    @(negedge clk);
    check("restart_addr", bus.out_addr, FIRST);
    drain();
    for (int i = 0; i < N; i++) check("mem_intact", mem[i], gold[i]);

    // Randomized phase: random contents, ready, start and rare resets
    for (int i = 0; i < N; i++) gold[i] = $urandom;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0;
    drain();
    for (int i = 0; i < N; i++) check("mem_intact_rand", mem[i], gold[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
